// File: rtl/rf_ctrl_pkg.sv
// Shared constants and helpers for the register-file writeback control slice.
//   DEF_XLEN   default datapath width
//   DEF_REG_AW default register address width
//   NUM_REGS   architectural register count at the default address width
//   DEF_CNT_W  default width of the per-register in-flight counters
//   onehot2idx encodes a one-hot vector (up to 8 bits) to its bit index
package rf_ctrl_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_REG_AW = 5;
    localparam int NUM_REGS   = 32;
    localparam int DEF_CNT_W  = 2;

    // OR-reduce of set-bit indices; exact for a one-hot or all-zero input.
    function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     in   N   request per requester
//   ptr     in   PW  highest-priority requester this cycle (must be < N)
//   gnt     out  N   one-hot grant to the first requester at or after ptr
//   gnt_idx out  PW  index of the granted requester (0 when nothing granted)
module rr_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);

    logic       found;
    int         idx;
    logic [7:0] gnt_pad;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_pad        = '0;
        gnt_pad[N-1:0] = gnt;
        gnt_idx        = PW'(onehot2idx(gnt_pad));
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file writeback scheduler: round-robin shares the single write port
// between NUM_SRC writeback sources and keeps a per-register in-flight counter
// scoreboard for RAW hazard detection at issue.
//   clk, rst                     clock (rising edge), async active-low reset
//   src_valid/src_ready          per-source request / one-hot grant
//   src_rd_addr/src_rd_data      packed per-source destination and data
//   rf_we/rf_rd_addr/rf_rd_data  registered register-file write port
//   issue_valid/issue_rd         instruction issue with destination
//   issue_ready                  low when issue_rd counter is saturated
//   rs1_addr/rs2_addr            hazard query operands
//   rs1_busy/rs2_busy            high when a write to the operand is pending
//   flush                        synchronous scoreboard clear
module rf_wb_scheduler
    import rf_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int XLEN    = DEF_XLEN,
    parameter int REG_AW  = DEF_REG_AW,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*REG_AW-1:0] src_rd_addr,
    input  logic [NUM_SRC*XLEN-1:0]   src_rd_data,
    output logic                      rf_we,
    output logic [REG_AW-1:0]         rf_rd_addr,
    output logic [XLEN-1:0]           rf_rd_data,
    input  logic                      issue_valid,
    input  logic [REG_AW-1:0]         issue_rd,
    output logic                      issue_ready,
    input  logic [REG_AW-1:0]         rs1_addr,
    input  logic [REG_AW-1:0]         rs2_addr,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    input  logic                      flush
);

    localparam int               PW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int               NREG    = 1 << REG_AW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PW-1:0]      ptr_q, ptr_d;
    logic [NUM_SRC-1:0] arb_gnt;
    logic [PW-1:0]      g_idx;
    logic               g_any;
    logic [REG_AW-1:0]  g_addr;
    logic [XLEN-1:0]    g_data;

    logic [CNT_W-1:0]   cnt_q [1:NREG-1];
    logic [CNT_W-1:0]   cnt_d [1:NREG-1];
    logic [CNT_W-1:0]   cnt_issue, cnt_rs1, cnt_rs2;
    logic               issue_fire;

    rr_arbiter #(
        .N  (NUM_SRC),
        .PW (PW)
    ) u_arb (
        .req     (src_valid),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (g_idx)
    );

    // Nothing may be consumed while reset is asserted.
    assign src_ready = arb_gnt & {NUM_SRC{rst}};
    assign g_any     = |src_ready;
    assign g_addr    = src_rd_addr[int'(g_idx)*REG_AW +: REG_AW];
    assign g_data    = src_rd_data[int'(g_idx)*XLEN +: XLEN];

    always_comb begin
        ptr_d = ptr_q;
        if (g_any) ptr_d = (int'(g_idx) == NUM_SRC - 1) ? '0 : g_idx + PW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q      <= '0;
            rf_we      <= 1'b0;
            rf_rd_addr <= '0;
            rf_rd_data <= '0;
        end else begin
            ptr_q <= ptr_d;
            // x0 writes are consumed but never reach the register file.
            rf_we <= g_any && (g_addr != '0);
            if (g_any) begin
                rf_rd_addr <= g_addr;
                rf_rd_data <= g_data;
            end
        end
    end

    // Counter lookups; x0 has no counter and always reads as idle.
    always_comb begin
        cnt_issue = '0;
        cnt_rs1   = '0;
        cnt_rs2   = '0;
        if (issue_rd != '0) cnt_issue = cnt_q[issue_rd];
        if (rs1_addr != '0) cnt_rs1   = cnt_q[rs1_addr];
        if (rs2_addr != '0) cnt_rs2   = cnt_q[rs2_addr];
    end

    // A same-cycle retirement to issue_rd frees a slot even at saturation.
    assign issue_ready = (issue_rd == '0) || (cnt_issue != CNT_MAX) ||
                         (g_any && (g_addr == issue_rd));
    assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);

    always_comb begin
        for (int r = 1; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (flush) begin
                cnt_d[r] = '0;
            end else begin
                if ((issue_fire && (int'(issue_rd) == r)) &&
                    !(g_any && (int'(g_addr) == r))) begin
                    cnt_d[r] = cnt_q[r] + CNT_W'(1);
                end else if (!(issue_fire && (int'(issue_rd) == r)) &&
                             (g_any && (int'(g_addr) == r)) && (cnt_q[r] != '0)) begin
                    cnt_d[r] = cnt_q[r] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 1; r < NREG; r++) cnt_q[r] <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    // The output-stage term covers the cycle before the register file commits.
    assign rs1_busy = (rs1_addr != '0) &&
                      ((cnt_rs1 != '0) || (rf_we && (rf_rd_addr == rs1_addr)));
    assign rs2_busy = (rs2_addr != '0) &&
                      ((cnt_rs2 != '0) || (rf_we && (rf_rd_addr == rs2_addr)));

endmodule
